mario_motion_ctrl: RTL and testbench

Per-frame motion sequencer for the player sprite. Turns button inputs and the current packed coordinate into one-cycle `Move_arrow`/`Move_speed` commands for the coordinate register block. It also runs the jump/gravity state machine and keeps the sprite inside the screen and above the floor. It sits between the button debouncers and the coordinate calculation block, with the coordinate fed back as an input.

---
 rtl/mario_pkg.sv | 36 +++
 rtl/frame_tick_gen.sv | 30 +++
 rtl/mario_motion_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mario_motion_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mario_pkg.sv
// rtl/mario_pkg.sv - shared motion encodings for the player sprite blocks
// Contents: FSM state encoding, Move_arrow bit indices, Btn bit indices,
//           coordinate/speed packing field positions, a small min helper.
package mario_pkg;

  localparam int AXIS_W = 16;
  typedef logic [AXIS_W-1:0] axis_t;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2
  } motion_state_t;

  // Move_arrow bit positions
  localparam int ARROW_UP    = 3;
  localparam int ARROW_DOWN  = 2;
  localparam int ARROW_LEFT  = 1;
  localparam int ARROW_RIGHT = 0;

  // Btn bit positions
  localparam int BTN_JUMP  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;

  // Coordinate = {x, y}, Move_speed = {vertical step, horizontal step}
  localparam int COORD_X_LSB = 16;
  localparam int COORD_Y_LSB = 0;
  localparam int SPEED_V_LSB = 16;
  localparam int SPEED_H_LSB = 0;

  function automatic axis_t min_axis(input axis_t a, input axis_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - free-running frame strobe generator
// Ports: clk  - system clock
//        rst  - asynchronous active-high reset
//        tick - high for the one cycle in which the count is TICK_DIV-1
module frame_tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/mario_motion_ctrl.sv
// rtl/mario_motion_ctrl.sv - per-frame jump/gravity/walk sequencer for the player sprite
// Ports: clk, rst     - system clock, asynchronous active-high reset
//        Btn        - {jump, left, right} levels, already synchronized
//        Coordinate - {x, y} fed back from the coordinate register block
//        Move_arrow - one-cycle {up, down, left, right} command
//        Move_speed - one-cycle {vertical step, horizontal step}
//        State      - GROUND/RISE/FALL
//        Frame_tick - single-cycle frame strobe
module mario_motion_ctrl
  import mario_pkg::*;
#(
  parameter int TICK_DIV   = 833333,
  parameter int WALK_SPEED = 4,
  parameter int JUMP_V     = 12,
  parameter int GRAVITY    = 1,
  parameter int MAX_FALL   = 10,
  parameter int FLOOR_Y    = 400,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 624
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  Btn,
  input  logic [31:0] Coordinate,
  output logic [3:0]  Move_arrow,
  output logic [31:0] Move_speed,
  output logic [1:0]  State,
  output logic        Frame_tick
);

  localparam axis_t WALK  = axis_t'(WALK_SPEED);
  localparam axis_t JUMP  = axis_t'(JUMP_V);
  localparam axis_t GRAV  = axis_t'(GRAVITY);
  localparam axis_t FALLM = axis_t'(MAX_FALL);
  localparam axis_t FLOOR = axis_t'(FLOOR_Y);
  localparam axis_t XMIN  = axis_t'(X_MIN);
  localparam axis_t XMAX  = axis_t'(X_MAX);
  // vel always holds the step for the *next* RISE frame, so the take-off
  // frame leaves JUMP_V-GRAVITY behind and the climb reads JUMP_V, JUMP_V-1, ...
  localparam axis_t JUMP_NEXT = (JUMP_V > GRAVITY) ? axis_t'(JUMP_V - GRAVITY) : axis_t'(0);

  motion_state_t state, state_n;
  axis_t         vel, vel_n;
  axis_t         x, y;
  axis_t         vstep, hstep;
  axis_t         fall_sum, fall_vel;
  logic [AXIS_W:0] land_sum;
  logic          vert_up, vert_down, horz_left, horz_right;
  logic          jump, left, right;
  logic          tick;
  logic [3:0]    arrow_n;
  logic [31:0]   speed_n;

  frame_tick_gen #(.TICK_DIV(TICK_DIV)) u_frame_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign Frame_tick = tick;
  assign State      = state;

  assign x     = Coordinate[COORD_X_LSB +: AXIS_W];
  assign y     = Coordinate[COORD_Y_LSB +: AXIS_W];
  assign jump  = Btn[BTN_JUMP];
  assign left  = Btn[BTN_LEFT];
  assign right = Btn[BTN_RIGHT];

  // Fall velocity for this frame and a 17-bit landing test so y+vel never wraps.
  assign fall_sum = vel + GRAV;
  assign fall_vel = min_axis(fall_sum, FALLM);
  assign land_sum = {1'b0, y} + {1'b0, fall_vel};

  // State, velocity and command registers. Decisions only commit on a tick;
  // the command registers reload every cycle so they are zero off-tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_FALL;
      vel        <= '0;
      Move_arrow <= '0;
      Move_speed <= '0;
    end else begin
      if (tick) begin
        state <= state_n;
        vel   <= vel_n;
      end
      Move_arrow <= arrow_n;
      Move_speed <= speed_n;
    end
  end

  // Vertical decision for the frame.
  always_comb begin
    state_n   = state;
    vel_n     = vel;
    vstep     = '0;
    vert_up   = 1'b0;
    vert_down = 1'b0;
    case (state)
      ST_GROUND: begin
        if (jump) begin
          vert_up = 1'b1;
          if (y < JUMP) begin
            vstep   = y;
            state_n = ST_FALL;
            vel_n   = '0;
          end else begin
            vstep   = JUMP;
            state_n = ST_RISE;
            vel_n   = JUMP_NEXT;
          end
        end else if (y < FLOOR) begin
          state_n = ST_FALL;
          vel_n   = '0;
        end
      end
      ST_RISE: begin
        if (vel > GRAV) begin
          vert_up = 1'b1;
          if (y < vel) begin
            // Top of screen: stop exactly at y=0 and start falling.
            vstep   = y;
            state_n = ST_FALL;
            vel_n   = '0;
          end else begin
            vstep = vel;
            vel_n = vel - GRAV;
          end
        end else begin
          state_n = ST_FALL;
          vel_n   = '0;
        end
      end
      ST_FALL: begin
        vert_down = 1'b1;
        if (land_sum >= {1'b0, FLOOR}) begin
          vstep   = (y < FLOOR) ? FLOOR - y : '0;
          state_n = ST_GROUND;
          vel_n   = '0;
        end else begin
          vstep = fall_vel;
          vel_n = fall_vel;
        end
      end
      default: begin
        state_n = ST_FALL;
        vel_n   = '0;
      end
    endcase
  end

  // Horizontal step and command formation.
  always_comb begin
    hstep      = '0;
    horz_left  = 1'b0;
    horz_right = 1'b0;
    arrow_n    = '0;
    speed_n    = '0;
    if (left && !right) begin
      horz_left = 1'b1;
      hstep     = min_axis(WALK, (x > XMIN) ? x - XMIN : axis_t'(0));
    end else if (right && !left) begin
      horz_right = 1'b1;
      hstep      = min_axis(WALK, (XMAX > x) ? XMAX - x : axis_t'(0));
    end
    if (tick) begin
      arrow_n[ARROW_UP]    = vert_up && (vstep != '0);
      arrow_n[ARROW_DOWN]  = vert_down && (vstep != '0);
      arrow_n[ARROW_LEFT]  = horz_left && (hstep != '0);
      arrow_n[ARROW_RIGHT] = horz_right && (hstep != '0);
      speed_n[SPEED_V_LSB +: AXIS_W] = vstep;
      speed_n[SPEED_H_LSB +: AXIS_W] = hstep;
    end
  end

endmodule

// File: tb/tb_mario_motion_ctrl.sv
// tb/tb_mario_motion_ctrl.sv - frame-table and scoreboard bench for mario_motion_ctrl
module tb_mario_motion_ctrl;

  localparam int TICK_DIV = 4;

  localparam logic [3:0] A_UP = 4'b1000;
  localparam logic [3:0] A_DN = 4'b0100;
  localparam logic [3:0] A_LF = 4'b0010;
  localparam logic [3:0] A_RT = 4'b0001;
  localparam logic [1:0] S_G  = 2'd0;
  localparam logic [1:0] S_R  = 2'd1;
  localparam logic [1:0] S_F  = 2'd2;

  typedef struct {
    logic [2:0]  btn;
    logic        glitch;
    logic        chk;
    logic [15:0] ex;
    logic [15:0] ey;
    logic        load;
    logic [15:0] lx;
    logic [15:0] ly;
    logic [3:0]  arrow;
    logic [15:0] vstep;
    logic [15:0] hstep;
    logic [1:0]  state;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  Btn = 3'b000;
  logic [31:0] Coordinate;
  logic [3:0]  Move_arrow;
  logic [31:0] Move_speed;
  logic [1:0]  State;
  logic        Frame_tick;

  logic        load_en = 1'b0;
  logic [15:0] load_x = 16'd0;
  logic [15:0] load_y = 16'd0;
  logic [15:0] cx, cy;
  logic [1:0]  tcnt;
  logic        cmd_due = 1'b0;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  logic p_chk = 1'b0, p_load = 1'b0, p_glitch = 1'b0;
  int   p_ex, p_ey, p_lx, p_ly;

  always #5 clk = ~clk;

  mario_motion_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .Btn        (Btn),
    .Coordinate (Coordinate),
    .Move_arrow (Move_arrow),
    .Move_speed (Move_speed),
    .State      (State),
    .Frame_tick (Frame_tick)
  );

  // Coordinate register block: resets to (320,100), applies one command per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx <= 16'd320;
      cy <= 16'd100;
    end else if (load_en) begin
      cx <= load_x;
      cy <= load_y;
    end else begin
      if (Move_arrow[0])      cx <= cx + Move_speed[15:0];
      else if (Move_arrow[1]) cx <= cx - Move_speed[15:0];
      if (Move_arrow[3])      cy <= cy - Move_speed[31:16];
      else if (Move_arrow[2]) cy <= cy + Move_speed[31:16];
    end
  end
  assign Coordinate = {cx, cy};

  // Expected frame phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tcnt <= 2'd0;
    else     tcnt <= tcnt + 2'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected command on the cycle after each tick, else demands silence.
  always @(negedge clk) begin
    if (rst) begin
      cmd_due = 1'b0;
    end else begin
      check("frame_tick", {31'd0, Frame_tick}, {31'd0, tcnt == 2'd3});
      if (cmd_due) begin
        if (sb.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          vec_t e;
          e = sb.pop_front();
          check("cmd_arrow", {28'd0, Move_arrow}, {28'd0, e.arrow});
          check("cmd_speed", Move_speed, {e.vstep, e.hstep});
          check("cmd_state", {30'd0, State}, {30'd0, e.state});
        end
      end else begin
        check("idle_arrow", {28'd0, Move_arrow}, 32'd0);
        check("idle_speed", Move_speed, 32'd0);
      end
      cmd_due = Frame_tick;
    end
  end

  task automatic expect_xy(input int ex, input int ey);
    p_chk = 1'b1; p_ex = ex; p_ey = ey;
  endtask

  task automatic load_xy(input int lx, input int ly);
    p_load = 1'b1; p_lx = lx; p_ly = ly;
  endtask

  task automatic add(input logic [2:0] b, input logic [3:0] a, input int v, input int h,
                     input logic [1:0] s);
    vec_t r;
    r.btn = b; r.glitch = p_glitch; r.chk = p_chk; r.ex = 16'(p_ex); r.ey = 16'(p_ey);
    r.load = p_load; r.lx = 16'(p_lx); r.ly = 16'(p_ly);
    r.arrow = a; r.vstep = 16'(v); r.hstep = 16'(h); r.state = s;
    vecs.push_back(r);
    p_chk = 1'b0; p_load = 1'b0; p_glitch = 1'b0;
  endtask

  task automatic wait_tick(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 4 * TICK_DIV && !seen; i++) begin
      @(negedge clk);
      if (Frame_tick) seen = 1'b1;
    end
    if (!seen) check("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic apply(input vec_t r);
    logic seen;
    @(negedge clk);
    if (r.chk) begin
      check("coord_x", {16'd0, cx}, {16'd0, r.ex});
      check("coord_y", {16'd0, cy}, {16'd0, r.ey});
    end
    Btn     = r.glitch ? (r.btn | 3'b100) : r.btn;
    load_x  = r.lx;
    load_y  = r.ly;
    load_en = r.load;
    @(negedge clk);
    load_en = 1'b0;
    Btn     = r.btn;
    wait_tick(seen);
    if (seen) sb.push_back(r);
    @(negedge clk);
  endtask

  initial begin
    vec_t r;
    logic seen;

    // Reset release: fall 1..10 (y=155), 24 x 10 (y=395), land with 5.
    for (int k = 1; k <= 10; k++) add(3'b000, A_DN, k, 0, S_F);
    for (int k = 0; k < 24; k++)  add(3'b000, A_DN, 10, 0, S_F);
    add(3'b000, A_DN, 5, 0, S_G);
    expect_xy(320, 400); add(3'b000, 4'b0000, 0, 0, S_G);
    // Walk right three frames.
    for (int k = 0; k < 3; k++) add(3'b001, A_RT, 0, 4, S_G);
    // Both directions: no horizontal move.
    expect_xy(332, 400); add(3'b011, 4'b0000, 0, 0, S_G);
    add(3'b011, 4'b0000, 0, 0, S_G);
    // Jump pulse only between ticks is ignored.
    expect_xy(332, 400); p_glitch = 1'b1; add(3'b000, 4'b0000, 0, 0, S_G);
    // Full jump: 12..2 up (y=323), apex frame, fall 1..10 (y=378), 10, 10, land with 2.
    expect_xy(332, 400); add(3'b100, A_UP, 12, 0, S_R);
    for (int k = 11; k >= 2; k--) add(3'b000, A_UP, k, 0, S_R);
    expect_xy(332, 323); add(3'b000, 4'b0000, 0, 0, S_F);
    for (int k = 1; k <= 10; k++) add(3'b000, A_DN, k, 0, S_F);
    add(3'b000, A_DN, 10, 0, S_F);
    add(3'b000, A_DN, 10, 0, S_F);
    add(3'b000, A_DN, 2, 0, S_G);
    // Right wall clamp.
    expect_xy(332, 400); load_xy(622, 400); add(3'b001, A_RT, 0, 2, S_G);
    expect_xy(624, 400); add(3'b001, 4'b0000, 0, 0, S_G);
    // Left wall clamp.
    load_xy(2, 400); add(3'b010, A_LF, 0, 2, S_G);
    expect_xy(0, 400); add(3'b010, 4'b0000, 0, 0, S_G);
    // Ceiling clamp mid-rise: y=20 -> 9 -> 0, then fall 1..10 (55), 34 x 10 (395), land 5.
    load_xy(320, 400); add(3'b100, A_UP, 12, 0, S_R);
    load_xy(320, 20);  add(3'b000, A_UP, 11, 0, S_R);
    expect_xy(320, 9); add(3'b000, A_UP, 9, 0, S_F);
    expect_xy(320, 0);
    for (int k = 1; k <= 10; k++) add(3'b000, A_DN, k, 0, S_F);
    for (int k = 0; k < 34; k++)  add(3'b000, A_DN, 10, 0, S_F);
    add(3'b000, A_DN, 5, 0, S_G);
    // Ground with y above floor: fall 1,2,3 then exact landing with 4.
    expect_xy(320, 400); load_xy(320, 390); add(3'b000, 4'b0000, 0, 0, S_F);
    for (int k = 1; k <= 3; k++) add(3'b000, A_DN, k, 0, S_F);
    add(3'b000, A_DN, 4, 0, S_G);
    // Jump while walking right.
    expect_xy(320, 400); add(3'b101, A_UP | A_RT, 12, 4, S_R);
    add(3'b001, A_UP | A_RT, 11, 4, S_R);

    @(negedge clk);
    check("rst_arrow", {28'd0, Move_arrow}, 32'd0);
    check("rst_speed", Move_speed, 32'd0);
    check("rst_state", {30'd0, State}, {30'd0, S_F});
    check("rst_tick",  {31'd0, Frame_tick}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Third rise frame, then reset while its command is on the outputs.
    wait_tick(seen);
    if (seen) begin
      r = vecs[vecs.size() - 1];
      r.arrow = A_UP | A_RT; r.vstep = 16'd10; r.hstep = 16'd4; r.state = S_R;
      sb.push_back(r);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    Btn = 3'b000;
    #1;
    check("midjump_arrow", {28'd0, Move_arrow}, 32'd0);
    check("midjump_speed", Move_speed, 32'd0);
    check("midjump_state", {30'd0, State}, {30'd0, S_F});
    check("midjump_x", {16'd0, cx}, 32'd320);
    check("midjump_y", {16'd0, cy}, 32'd100);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    r.btn = 3'b000; r.glitch = 1'b0; r.chk = 1'b1; r.ex = 16'd320; r.ey = 16'd100;
    r.load = 1'b0; r.lx = 16'd0; r.ly = 16'd0;
    r.arrow = A_DN; r.vstep = 16'd1; r.hstep = 16'd0; r.state = S_F;
    apply(r);
    @(negedge clk);
    check("sb_drain", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
